down_counter_timer: RTL and testbench

//  Loadable down-counting timer with borrow-out. It is the decrementing counterpart of the

---
 rtl/down_counter_timer.sv | 130 +++++++++++++
 tb/tb_down_counter_timer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with borrow-out, one-shot / auto-reload modes
// and start/pause/resume control. All outputs come straight from registers.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] s,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] w_s_nxt;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             r_bo;
  logic             w_bo_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // State, count, reload value and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_s      <= {WIDTH{1'b0}};
      r_reload <= {WIDTH{1'b0}};
      r_bo     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_s      <= w_s_nxt;
      r_reload <= w_reload_nxt;
      r_bo     <= w_bo_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state, next-count and borrow decision; load overrides all state logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_reload_nxt = r_reload;
    w_bo_nxt     = 1'b0;
    if (load) begin
      w_s_nxt      = load_val;
      w_reload_nxt = load_val;
      w_state_nxt  = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (tick_en) begin
            if (r_s != {WIDTH{1'b0}}) begin
              w_s_nxt = r_s - WIDTH'(1);
            end else begin
              // Terminal tick: auto_reload only matters here.
              w_bo_nxt = 1'b1;
              if (auto_reload) begin
                w_s_nxt = r_reload;
              end else begin
                w_s_nxt     = {WIDTH{1'b0}};
                w_state_nxt = ST_DONE;
              end
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (start && !pause) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_DONE: begin
          if (start) begin
            w_s_nxt     = r_reload;
            w_state_nxt = ST_RUN;
          end else begin
            w_s_nxt     = {WIDTH{1'b0}};
            w_state_nxt = ST_DONE;
          end
        end
        default: begin
          w_s_nxt     = {WIDTH{1'b0}};
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
    // Status flags are registered decodes of the state being entered.
    w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  assign s    = r_s;
  assign bo   = r_bo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench: directed vectors, a mode-level reference model compared
// every cycle, plus literal expectations for the documented scenarios.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] s;
  logic       bo;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Reference model: operating mode as text, count as plain integer.
  string m_mode = "IDLE";
  int    m_cnt = 0;
  int    m_reload = 0;
  bit    m_bo = 1'b0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .auto_reload(auto_reload),
    .s(s), .bo(bo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model update: one timer step per clock, immediate clear on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= "IDLE"; m_cnt <= 0; m_reload <= 0; m_bo <= 1'b0;
    end else begin
      m_bo <= 1'b0;
      if (load) begin
        m_cnt <= int'(load_val); m_reload <= int'(load_val); m_mode <= "IDLE";
      end else if (m_mode == "IDLE") begin
        if (start) m_mode <= "RUN";
      end else if (m_mode == "RUN") begin
        if (pause) m_mode <= "PAUSE";
        else if (tick_en && m_cnt > 0) m_cnt <= m_cnt - 1;
        else if (tick_en) begin
          m_bo <= 1'b1;
          if (auto_reload) m_cnt <= m_reload;
          else m_mode <= "DONE";
        end
      end else if (m_mode == "PAUSE") begin
        if (start && !pause) m_mode <= "RUN";
      end else if (m_mode == "DONE") begin
        if (start) begin m_cnt <= m_reload; m_mode <= "RUN"; end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("model_s", 32'(s), 32'(m_cnt));
    check("model_bo", 32'(bo), 32'(m_bo));
    check("model_busy", 32'(busy), 32'((m_mode == "RUN") || (m_mode == "PAUSE")));
    check("model_done", 32'(done), 32'(m_mode == "DONE"));
  end

  int bo_cnt;

  initial begin
    cyc(2);
    check("rst_s", 32'(s), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    cyc(1);

    // 1: one-shot from 3
    load = 1'b1; load_val = 4'd3; cyc(1);
    check("t1_load_s", 32'(s), 32'd3);
    load = 1'b0; start = 1'b1; cyc(1);
    check("t1_busy", 32'(busy), 32'd1);
    start = 1'b0; tick_en = 1'b1; cyc(3);
    check("t1_s0", 32'(s), 32'd0);
    check("t1_no_bo_yet", 32'(bo), 32'd0);
    cyc(1);
    check("t1_bo", 32'(bo), 32'd1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy0", 32'(busy), 32'd0);
    cyc(1);
    check("t1_bo_pulse", 32'(bo), 32'd0);
    check("t1_done_hold", 32'(done), 32'd1);
    tick_en = 1'b0;

    // 2: auto-reload from 9, period 10
    load = 1'b1; load_val = 4'd9; auto_reload = 1'b1; cyc(1);
    load = 1'b0; start = 1'b1; cyc(1);
    start = 1'b0; tick_en = 1'b1;
    bo_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (bo) bo_cnt++;
      if (i == 9) check("t2_reload_s", 32'(s), 32'd9);
    end
    check("t2_bo_count", 32'(bo_cnt), 32'd3);
    check("t2_done", 32'(done), 32'd0);
    tick_en = 1'b0;

    // 3: pause at 4 with ticks, then resume
    load = 1'b1; load_val = 4'd5; auto_reload = 1'b0; cyc(1);
    load = 1'b0; start = 1'b1; cyc(1);
    start = 1'b0; tick_en = 1'b1; cyc(1);
    check("t3_s4", 32'(s), 32'd4);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("t3_pause_s", 32'(s), 32'd4);
      check("t3_pause_busy", 32'(busy), 32'd1);
    end
    pause = 1'b0; start = 1'b1; cyc(1);
    check("t3_resume_s", 32'(s), 32'd4);
    start = 1'b0; cyc(1);
    check("t3_s3", 32'(s), 32'd3);

    // 4: load beats counting
    load = 1'b1; load_val = 4'd4; tick_en = 1'b0; cyc(1);
    load = 1'b0; start = 1'b1; cyc(1);
    start = 1'b0; tick_en = 1'b1; cyc(2);
    check("t4_s2", 32'(s), 32'd2);
    load = 1'b1; load_val = 4'd7; cyc(1);
    check("t4_s7", 32'(s), 32'd7);
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_bo", 32'(bo), 32'd0);
    load = 1'b0; tick_en = 1'b0;

    // 5: async reset mid-run
    load = 1'b1; load_val = 4'd6; cyc(1);
    load = 1'b0; start = 1'b1; cyc(1);
    start = 1'b0; tick_en = 1'b1; cyc(1);
    check("t5_s5", 32'(s), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_s", 32'(s), 32'd0);
    check("t5_rst_bo", 32'(bo), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    cyc(2);
    rst = 1'b0; tick_en = 1'b0; cyc(1);

    // 6: reload 0 auto mode, tick every 3rd cycle; then DONE and restart
    load = 1'b1; load_val = 4'd0; auto_reload = 1'b1; cyc(1);
    load = 1'b0; start = 1'b1; cyc(1);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick_en = (i % 3 == 0);
      cyc(1);
      check("t6_bo", 32'(bo), (i % 3 == 0) ? 32'd1 : 32'd0);
      check("t6_s", 32'(s), 32'd0);
    end
    auto_reload = 1'b0; tick_en = 1'b1; cyc(1);
    check("t6_done", 32'(done), 32'd1);
    tick_en = 1'b0; start = 1'b1; cyc(1);
    check("t6_restart_done", 32'(done), 32'd0);
    check("t6_restart_busy", 32'(busy), 32'd1);
    check("t6_restart_s", 32'(s), 32'd0);
    start = 1'b0; cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
